// File: rtl/des_pkg.sv
// Shared DES constants: state encoding, round count, IP/FP tables and
// the small helpers the iterative core uses to permute blocks and pick
// the decrypt subkey index.
package des_pkg;

  localparam logic [4:0] ROUNDS = 5'd16;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } state_t;

  // Tables use DES bit numbering: bit 1 is the most significant bit.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      p[6'(63 - i)] = d[6'(64 - IP_TAB[i])];
    end
    return p;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      p[6'(63 - i)] = d[6'(64 - FP_TAB[i])];
    end
    return p;
  endfunction

  // Decryption walks the key schedule backwards: round n uses subkey 17-n.
  function automatic logic [4:0] dec_index(input logic [4:0] rnd);
    return 5'd17 - rnd;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES Feistel function: expand R to 48 bits, mix in the round subkey,
// squeeze through S1..S8 and apply the P permutation. Purely combinational.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is stored row-major: index = {row(b1,b6), column(b2..b5)}.
  localparam logic [3:0] S_TAB [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  logic [47:0] e_out;
  logic [47:0] mixed;
  logic [31:0] s_out;
  logic [5:0]  six;

  // Expansion, key mixing, S-box substitution and P permutation in one pass.
  always_comb begin
    e_out = '0;
    mixed = '0;
    s_out = '0;
    six   = '0;
    f     = '0;
    for (int i = 0; i < 48; i++) begin
      e_out[6'(47 - i)] = r[5'(32 - E_TAB[i])];
    end
    mixed = e_out ^ k;
    for (int b = 0; b < 8; b++) begin
      six = mixed[6'(47 - 6 * b) -: 6];
      s_out[5'(31 - 4 * b) -: 4] = S_TAB[3'(b)][{six[5], six[0], six[4:1]}];
    end
    for (int i = 0; i < 32; i++) begin
      f[5'(31 - i)] = s_out[5'(32 - P_TAB[i])];
    end
  end

endmodule

// File: rtl/key_gen.sv
// DES key schedule: PC1 drops the parity bits, the C/D halves rotate per
// round and PC2 picks the 48-bit subkey. subkeys[0] is K1, subkeys[15] is K16.
module key_gen
  import des_pkg::*;
(
  input  logic [63:0]        key,
  output logic [15:0][47:0]  subkeys
);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [55:0] cd;
  logic [55:0] cd_rot;
  logic [27:0] c;
  logic [27:0] d;

  // Unrolled schedule: all sixteen subkeys are available combinationally.
  always_comb begin
    cd      = '0;
    cd_rot  = '0;
    subkeys = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    end
    c = cd[55:28];
    d = cd[27:0];
    for (int rr = 0; rr < 16; rr++) begin
      if (SHIFT_TAB[rr] == 1) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
      cd_rot = {c, d};
      for (int j = 0; j < 48; j++) begin
        subkeys[4'(rr)][6'(47 - j)] = cd_rot[6'(56 - PC2_TAB[j])];
      end
    end
  end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block,
// a one-cycle DONE state that can immediately accept the next block.
module des_iter_core
  import des_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_decrypt,
  input  logic [63:0] i_data,
  input  logic [63:0] i_key,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_data
);

  state_t state;
  state_t next_state;

  logic [63:0]       key_reg;
  logic              dec;
  logic [31:0]       l;
  logic [31:0]       r;
  logic [4:0]        rnd;
  logic              load;
  logic [15:0][47:0] subkeys;
  logic [4:0]        sel;
  logic [47:0]       round_key;
  logic [31:0]       f_out;

  key_gen key_gen_i (
    .key     (key_reg),
    .subkeys (subkeys)
  );

  des_f des_f_i (
    .r (r),
    .k (round_key),
    .f (f_out)
  );

  // Subkey select: forward order for encrypt, reversed for decrypt.
  always_comb begin
    sel       = dec ? dec_index(rnd) : rnd;
    round_key = subkeys[4'(sel - 5'd1)];
  end

  // State register; reset aborts any block in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; DONE doubles as an accept slot.
  always_comb begin
    next_state = state;
    o_ready    = 1'b1;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        o_ready = 1'b0;
        o_busy  = 1'b1;
        if (rnd == ROUNDS) begin
          next_state = DONE;
        end
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch inputs on accept, run rounds, publish the swapped result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_reg <= '0;
      dec     <= 1'b0;
      l       <= '0;
      r       <= '0;
      rnd     <= '0;
      o_data  <= '0;
    end else if (load) begin
      key_reg  <= i_key;
      dec      <= i_decrypt;
      {l, r}   <= ip_perm(i_data);
      rnd      <= 5'd1;
    end else if (state == RUN) begin
      l <= r;
      r <= l ^ f_out;
      if (rnd == ROUNDS) begin
        o_data <= fp_perm({l ^ f_out, r});
        rnd    <= '0;
      end else begin
        rnd <= rnd + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Self-checking bench for des_iter_core. Expected results come from known
// DES vectors and are queued at accept time; a monitor pops them on o_done
// and checks both the value and the accept-to-done latency.
module tb_des_iter_core;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT_B   = 64'h8787878787878787;
  localparam logic [63:0] CT_B   = 64'h0000000000000000;
  localparam logic [63:0] CT_Z   = 64'h8CA64DE9C1B123A7;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_decrypt;
  logic [63:0] i_data;
  logic [63:0] i_key;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    logic [63:0] data;
    int          accept_cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  des_iter_core dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_decrypt (i_decrypt),
    .i_data    (i_data),
    .i_key     (i_key),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_data    (o_data)
  );

  always #5 i_clk = ~i_clk;

  // Edge counter: at a negedge, cyc is the number of the edge just taken.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard monitor: every o_done must match the oldest queued block.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done at edge %0d, o_data=%h, expected no completion", cyc, o_data);
      end else begin
        e = sb.pop_front();
        tests_run++;
        if (o_data !== e.data) begin
          tests_failed++;
          $display("[TB] FAIL %s data got %h expected %h", e.tag, o_data, e.data);
        end
        tests_run++;
        if (cyc !== e.accept_cyc + 16) begin
          tests_failed++;
          $display("[TB] FAIL %s latency done at edge %0d expected edge %0d", e.tag, cyc, e.accept_cyc + 16);
        end
      end
    end
  end

  // Drive a block at a negedge; the DUT accepts it on the next rising edge.
  task automatic start_block(input logic [63:0] key, input logic [63:0] data,
                             input logic decrypt, input logic [63:0] expv, input string tag);
    i_key     = key;
    i_data    = data;
    i_decrypt = decrypt;
    i_start   = 1'b1;
    sb.push_back('{data: expv, accept_cyc: cyc + 1, tag: tag});
  endtask

  task automatic scramble_inputs();
    i_data    = {$urandom, $urandom};
    i_key     = {$urandom, $urandom};
    i_decrypt = ~i_decrypt;
  endtask

  // Wait (bounded) until every queued block has completed.
  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_timeout pending=%0d expected 0 after %0d cycles", sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic run_single(input logic [63:0] key, input logic [63:0] data,
                            input logic decrypt, input logic [63:0] expv, input string tag);
    @(negedge i_clk);
    start_block(key, data, decrypt, expv, tag);
    @(negedge i_clk);
    i_start = 1'b0;
    scramble_inputs();
    drain(40);
  endtask

  task automatic test_reset();
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_decrypt = 1'b0;
    i_data    = '0;
    i_key     = '0;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b expected 1", o_ready); end
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b expected 0", o_busy); end
    tests_run++;
    if (o_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b expected 0", o_done); end
    tests_run++;
    if (o_data !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h expected 0", o_data); end
    // Reset and start together: reset must win.
    i_start = 1'b1;
    i_key   = KEY_A;
    i_data  = PT_A;
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_start = 1'b0;
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_vs_start busy got %b expected 0", o_busy); end
    repeat (20) @(negedge i_clk);
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_vs_start ready got %b expected 1", o_ready); end
  endtask

  task automatic test_encrypt();
    @(negedge i_clk);
    start_block(KEY_A, PT_A, 1'b0, CT_A, "enc_fips");
    @(negedge i_clk);
    i_start = 1'b0;
    scramble_inputs();
    tests_run++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL enc_run_flags busy=%b ready=%b expected busy=1 ready=0", o_busy, o_ready);
    end
    tests_run++;
    if (dut.subkeys[0] !== 48'h1B02EFFC7072) begin
      tests_failed++;
      $display("[TB] FAIL subkey1 got %h expected 1b02effc7072", dut.subkeys[0]);
    end
    drain(40);
  endtask

  task automatic test_decrypt();
    run_single(KEY_A, CT_A, 1'b1, PT_A, "dec_fips");
    run_single(KEY_B, PT_B, 1'b0, CT_B, "enc_8787");
    run_single(KEY_B, CT_B, 1'b1, PT_B, "dec_8787");
    run_single(64'h0101010101010101, 64'h0, 1'b0, CT_Z, "enc_parity_key");
    run_single(64'h0, 64'h0, 1'b0, CT_Z, "enc_zero_key");
  endtask

  task automatic test_back_to_back();
    logic [63:0] keys [3];
    logic [63:0] datas [3];
    logic        decs [3];
    logic [63:0] exps [3];
    keys  = '{KEY_A, KEY_B, KEY_A};
    datas = '{PT_A, PT_B, CT_A};
    decs  = '{1'b0, 1'b0, 1'b1};
    exps  = '{CT_A, CT_B, PT_A};
    @(negedge i_clk);
    for (int b = 0; b < 3; b++) begin
      start_block(keys[b], datas[b], decs[b], exps[b], $sformatf("b2b_%0d", b));
      @(negedge i_clk);
      i_data = {$urandom, $urandom};
      i_key  = {$urandom, $urandom};
      i_decrypt = ~decs[b];
      if (b == 2) begin
        i_start = 1'b0;
      end else begin
        repeat (16) @(negedge i_clk);
      end
    end
    drain(60);
  endtask

  task automatic test_start_while_busy();
    @(negedge i_clk);
    start_block(KEY_B, CT_B, 1'b1, PT_B, "busy_ignore");
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL busy_flags round %0d ready=%b busy=%b expected ready=0 busy=1", k + 1, o_ready, o_busy);
      end
      if (k == 2 || k == 14) begin
        i_start   = 1'b1;
        i_data    = {$urandom, $urandom};
        i_key     = {$urandom, $urandom};
        i_decrypt = 1'b0;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    drain(5);
    repeat (20) @(negedge i_clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge i_clk);
    start_block(KEY_A, PT_A, 1'b0, CT_A, "aborted");
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    i_rst = 1'b1;
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    tests_run++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_flags ready=%b busy=%b done=%b expected 1/0/0", o_ready, o_busy, o_done);
    end
    tests_run++;
    if (o_data !== 64'h0) begin tests_failed++; $display("[TB] FAIL midrun_reset_data got %h expected 0", o_data); end
    repeat (25) @(negedge i_clk);
    tests_run++;
    if (o_data !== 64'h0) begin tests_failed++; $display("[TB] FAIL midrun_no_result got %h expected 0", o_data); end
    run_single(KEY_A, CT_A, 1'b1, PT_A, "after_reset");
  endtask

  task automatic test_hold();
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      tests_run++;
      if (o_data !== PT_A || o_done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold cycle %0d data=%h done=%b expected data=%h done=0", k, o_data, o_done, PT_A);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
